svm_decision: RTL and testbench
===============================

# svm_decision

Final classification stage of the SVM accelerator, directly downstream of the SVM control/systolic datapath. It consumes the per-support-vector stream of alpha weights and kernel values produced during the V_MATMUL2 and A_MATMUL2 phases. It accumulates the valence and arousal decision functions, adds biases, takes the sign, and presents a two-bit classification on a valid/ready output whose handshake (`dout_fire`) releases the upstream read FSM.

## Interface
- `NBITS`, 16: alpha weight width, signed.
- `KBITS`, 32: kernel value width, signed.
- `ACC_BITS`, 56: accumulator width, signed. Must be ≥ NBITS+KBITS+LOG_SUP_WIDTH.
- `VSUP_WIDTH`, 64: valence support-vector count.
- `ASUP_WIDTH`, 64: arousal support-vector count.
- `LOG_SUP_WIDTH`, 7: counter width. Must satisfy 2^LOG_SUP_WIDTH > max(VSUP_WIDTH, ASUP_WIDTH).
- `V_BIAS`, 0: signed ACC_BITS valence bias.
- `A_BIAS`, 0: signed ACC_BITS arousal bias.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset
- `alpha`  in  NBITS  signed alpha of current support vector
- `kernel`  in  KBITS  signed kernel value, aligned with `alpha`
- `v_alpha_valid`  in  1  `alpha`/`kernel` belong to valence
- `a_alpha_valid`  in  1  `alpha`/`kernel` belong to arousal
- `dout_valid`  out  1  classification available
- `dout_ready`  in  1  consumer accepts
- `dout_fire`  out  1  `dout_valid && dout_ready`; fed back to control
- `valence`  out  1  1 if valence score ≥ 0
- `arousal`  out  1  1 if arousal score ≥ 0
- `overrun`  out  1  sticky error flag

Reset is `rst`: synchronous, active-high. The clock is `clk`.

## Operation
- Stage 1: on any valid, register `prod = alpha*kernel` (signed, NBITS+KBITS bits), together with a tag (V/A) and a prod_valid bit.
- Stage 2: when prod_valid, sign-extend prod to ACC_BITS and add it into the accumulator.
- FSM states:
  - ACC_V: accumulator is preloaded with V_BIAS. Count valence samples in `cnt`. When the VSUP_WIDTH-th product is accumulated:
    - latch `valence_r = ~acc[ACC_BITS-1]`;
    - load acc with A_BIAS;
    - clear `cnt`;
    - go to ACC_A.
  - ACC_A: same procedure for arousal. When the ASUP_WIDTH-th product is accumulated:
    - latch `arousal_r`;
    - go to HOLD.
  - HOLD: `dout_valid`=1, with outputs stable. On `dout_fire`: preload acc with V_BIAS, clear `cnt`, go to ACC_V.
- Sample/state mismatches:
  - `v_alpha_valid` in ACC_A or HOLD, or `a_alpha_valid` in ACC_V or HOLD: the sample is dropped and `overrun` is set.
  - Both valids high in the same cycle: the sample is dropped and `overrun` is set.
  - A product already in stage 1 when the state flips is still accumulated into its tagged phase. The phase flip occurs only after the final product has been accumulated, so a sample arriving one cycle after the last V sample is legal.
- `overrun` clears only on `rst`.
- `valence`/`arousal` are driven from registers and are meaningful only while `dout_valid`.
- Counters do not wrap: the compare against VSUP_WIDTH-1/ASUP_WIDTH-1 ends the phase.

## Timing
- Reset values:
  - `dout_valid`, `valence`, `arousal`, `overrun` = 0;
  - state = ACC_V;
  - acc = V_BIAS;
  - `cnt` = 0;
  - prod_valid = 0.
- Latency:
  - Sample presented in cycle t → product registered at edge t+1 → accumulated at edge t+2.
  - Last arousal sample in cycle t → `dout_valid` high from cycle t+3.
- Handshake:
  - `dout_valid` is not withdrawn until fire.
  - `dout_ready` may be high before valid.
  - Fire is a single cycle. `dout_valid` is 0 the cycle after fire.
- Back-to-back: the first valence sample of the next vector is legal in the cycle after fire.
- `rst` mid-phase aborts the computation with no output. The pipeline is flushed and the block is ready for V samples one cycle after `rst` is deasserted.

## Configuration
- `SVM_DECISION_SATURATE_EN` defined:
  - accumulator adds saturate to ACC_BITS signed max/min;
  - on saturation, a second sticky `sat` bit is set and ORed into `overrun`.
- Not defined: two's-complement wrap, with no saturation detection.

## Structure
- The shared package `svm_pkg` holds:
  - the state enum `svm_dec_state_t` (ACC_V, ACC_A, HOLD);
  - the NBITS/KBITS/ACC_BITS width constants shared with the control block.
- One sub-module: `svm_mac`, containing the product register, accumulator, optional saturation, and preload port. The FSM, counters, and handshake stay in the top level.

## Test plan
- VSUP=ASUP=4, biases 0:
  - alphas {1,2,3,4} with kernels {10,−1,−1,−1} → valence score 1 → `valence`=1;
  - arousal alphas {1,1,1,1} with kernels {−5,1,1,1} → score −2 → `arousal`=0;
  - `dout_valid` 3 cycles after the last sample.
- Score exactly 0 (V_BIAS=−6, products sum to 6) → `valence`=1 (tie counts as positive).
- `dout_ready` held low 10 cycles → `dout_valid`, `valence`, `arousal` stable. Raise ready → one-cycle `dout_fire`. Next V stream accepted the following cycle; a second classification is correct.
- `v_alpha_valid` during HOLD, and both valids high in ACC_V → `overrun`=1, accumulators unaffected, result unchanged.
- `rst` pulsed after 2 of 4 valence samples → no `dout_valid`. A fresh full stream afterwards yields the correct result.
- With `SVM_DECISION_SATURATE_EN`, ACC_BITS=20, alpha=32767 and kernel=32767 ×4 → acc clamps at 524287, `overrun`=1. Without the macro → wrapped value and `overrun`=0.

Source files
------------

// File: rtl/svm_pkg.sv
// ---------------------------------------------------------------------------
// svm_pkg
//   Types and width constants shared by the SVM control block and the final
//   decision stage.
//   svm_dec_state_t : decision FSM states (valence accumulate, arousal
//                     accumulate, hold result for the consumer).
//   SVM_NBITS/SVM_KBITS/SVM_ACC_BITS : alpha, kernel and accumulator widths.
// ---------------------------------------------------------------------------
package svm_pkg;

    typedef enum logic [1:0] {
        ACC_V = 2'd0,
        ACC_A = 2'd1,
        HOLD  = 2'd2
    } svm_dec_state_t;

    localparam int SVM_NBITS    = 16;
    localparam int SVM_KBITS    = 32;
    localparam int SVM_ACC_BITS = 56;

endpackage

// File: rtl/svm_decision_mac.sv
// ---------------------------------------------------------------------------
// svm_mac
//   Two-stage multiply-accumulate for the SVM decision stage: a registered
//   alpha*kernel product (with phase tag) followed by an accumulator that
//   can be preloaded with a bias.
//   Build option: SVM_DECISION_SATURATE_EN clamps the accumulator to its
//   signed range and raises a sticky sat_o; otherwise the sum wraps.
//
//   clk, rst       : clock, synchronous active-high reset
//   alpha_i        : signed alpha weight
//   kernel_i       : signed kernel value
//   in_vld_i       : alpha/kernel accepted this cycle
//   in_tag_i       : phase of the accepted sample (0 valence, 1 arousal)
//   preload_i      : replace the accumulator with preload_val_i
//   preload_val_i  : bias to load
//   prod_vld_o     : stage-1 product is valid (will be added this cycle)
//   prod_tag_o     : phase tag of the stage-1 product
//   sum_neg_o      : sign of accumulator plus stage-1 product
//   sat_o          : sticky saturation flag (always 0 without the option)
// ---------------------------------------------------------------------------
module svm_mac
    import svm_pkg::*;
#(
    parameter int NBITS    = SVM_NBITS,
    parameter int KBITS    = SVM_KBITS,
    parameter int ACC_BITS = SVM_ACC_BITS,
    parameter logic signed [ACC_BITS-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [NBITS-1:0]    alpha_i,
    input  logic signed [KBITS-1:0]    kernel_i,
    input  logic                       in_vld_i,
    input  logic                       in_tag_i,
    input  logic                       preload_i,
    input  logic signed [ACC_BITS-1:0] preload_val_i,
    output logic                       prod_vld_o,
    output logic                       prod_tag_o,
    output logic                       sum_neg_o,
    output logic                       sat_o
);

    localparam int PROD_W = NBITS + KBITS;
    // One guard bit above the wider operand so overflow is visible
    localparam int SUM_W  = ((ACC_BITS > PROD_W) ? ACC_BITS : PROD_W) + 1;

    logic signed [PROD_W-1:0]   prod_q;
    logic                       prod_vld_q;
    logic                       prod_tag_q;
    logic signed [ACC_BITS-1:0] acc_q;
    logic signed [ACC_BITS-1:0] acc_d;
    logic signed [ACC_BITS-1:0] acc_add;
    logic signed [SUM_W-1:0]    sum_w;

    assign sum_w = SUM_W'(acc_q) + SUM_W'(prod_q);

`ifdef SVM_DECISION_SATURATE_EN
    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    function automatic logic sum_ovf(input logic signed [SUM_W-1:0] v);
        return (v > SUM_W'(ACC_MAX)) || (v < SUM_W'(ACC_MIN));
    endfunction

    function automatic logic signed [ACC_BITS-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(ACC_MAX)) return ACC_MAX;
        if (v < SUM_W'(ACC_MIN)) return ACC_MIN;
        return ACC_BITS'(v);
    endfunction

    logic sat_q;

    assign acc_add = sat_acc(sum_w);
    assign sat_o   = sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (prod_vld_q && sum_ovf(sum_w)) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign acc_add = ACC_BITS'(sum_w);
    assign sat_o   = 1'b0;
`endif

    // Preload wins: the final product of a phase is consumed through
    // sum_neg_o in the same cycle the next bias is loaded.
    always_comb begin
        acc_d = acc_q;
        if (preload_i) begin
            acc_d = preload_val_i;
        end else if (prod_vld_q) begin
            acc_d = acc_add;
        end
    end

    // Stage 1: product register
    always_ff @(posedge clk) begin
        if (in_vld_i) begin
            prod_q <= PROD_W'(alpha_i) * PROD_W'(kernel_i);
        end
    end

    // Stage 2: accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_vld_q <= 1'b0;
            prod_tag_q <= 1'b0;
            acc_q      <= RST_VAL;
        end else begin
            prod_vld_q <= in_vld_i;
            prod_tag_q <= in_tag_i;
            acc_q      <= acc_d;
        end
    end

    assign prod_vld_o = prod_vld_q;
    assign prod_tag_o = prod_tag_q;
    assign sum_neg_o  = acc_add[ACC_BITS-1];

endmodule

// File: rtl/svm_decision.sv
// ---------------------------------------------------------------------------
// svm_decision
//   Final SVM classification: accumulates the valence then arousal decision
//   functions from an alpha/kernel stream, adds biases, takes the signs and
//   holds a two-bit result on a valid/ready output.
//   Build option: SVM_DECISION_SATURATE_EN (saturating accumulator; a
//   saturation event also raises overrun).
//
//   clk, rst       : clock, synchronous active-high reset
//   alpha, kernel  : signed support-vector weight and kernel value
//   v_alpha_valid  : sample belongs to the valence phase
//   a_alpha_valid  : sample belongs to the arousal phase
//   dout_valid     : classification available
//   dout_ready     : consumer accepts
//   dout_fire      : dout_valid && dout_ready, returned to control
//   valence        : valence score >= 0
//   arousal        : arousal score >= 0
//   overrun        : sticky error (misplaced sample or saturation)
// ---------------------------------------------------------------------------
module svm_decision
    import svm_pkg::*;
#(
    parameter int NBITS         = SVM_NBITS,
    parameter int KBITS         = SVM_KBITS,
    parameter int ACC_BITS      = SVM_ACC_BITS,
    parameter int VSUP_WIDTH    = 64,
    parameter int ASUP_WIDTH    = 64,
    parameter int LOG_SUP_WIDTH = 7,
    parameter logic signed [ACC_BITS-1:0] V_BIAS = '0,
    parameter logic signed [ACC_BITS-1:0] A_BIAS = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [NBITS-1:0] alpha,
    input  logic signed [KBITS-1:0] kernel,
    input  logic                    v_alpha_valid,
    input  logic                    a_alpha_valid,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_fire,
    output logic                    valence,
    output logic                    arousal,
    output logic                    overrun
);

    localparam logic [LOG_SUP_WIDTH-1:0] V_LAST = LOG_SUP_WIDTH'(VSUP_WIDTH - 1);
    localparam logic [LOG_SUP_WIDTH-1:0] A_LAST = LOG_SUP_WIDTH'(ASUP_WIDTH - 1);

    svm_dec_state_t             state_q;
    logic [LOG_SUP_WIDTH-1:0]   cnt_q;
    logic                       dout_valid_q;
    logic                       valence_q;
    logic                       arousal_q;
    logic                       overrun_q;

    logic                       prod_vld;
    logic                       prod_tag;
    logic                       sum_neg;
    logic                       sat;
    logic                       last_v;
    logic                       last_a;
    logic                       accept_v;
    logic                       accept_a;
    logic                       drop;
    logic                       fire;
    logic                       preload;
    logic signed [ACC_BITS-1:0] preload_val;

    // The final product of a phase sits in stage 1 one cycle before the
    // state flips; samples are judged against the phase they will land in,
    // so the first arousal sample may follow the last valence one directly.
    assign last_v   = prod_vld && !prod_tag && (state_q == ACC_V) && (cnt_q == V_LAST);
    assign last_a   = prod_vld &&  prod_tag && (state_q == ACC_A) && (cnt_q == A_LAST);
    assign accept_v = v_alpha_valid && !a_alpha_valid && (state_q == ACC_V) && !last_v;
    assign accept_a = a_alpha_valid && !v_alpha_valid &&
                      (((state_q == ACC_A) && !last_a) || last_v);
    assign drop     = (v_alpha_valid || a_alpha_valid) && !(accept_v || accept_a);
    assign fire     = dout_valid_q && dout_ready;

    assign preload     = last_v || fire;
    assign preload_val = last_v ? A_BIAS : V_BIAS;

    svm_mac #(
        .NBITS    (NBITS),
        .KBITS    (KBITS),
        .ACC_BITS (ACC_BITS),
        .RST_VAL  (V_BIAS)
    ) u_mac (
        .clk           (clk),
        .rst           (rst),
        .alpha_i       (alpha),
        .kernel_i      (kernel),
        .in_vld_i      (accept_v || accept_a),
        .in_tag_i      (accept_a),
        .preload_i     (preload),
        .preload_val_i (preload_val),
        .prod_vld_o    (prod_vld),
        .prod_tag_o    (prod_tag),
        .sum_neg_o     (sum_neg),
        .sat_o         (sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACC_V;
            cnt_q        <= '0;
            dout_valid_q <= 1'b0;
            valence_q    <= 1'b0;
            arousal_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (drop) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ACC_V: begin
                    if (last_v) begin
                        valence_q <= ~sum_neg;
                        cnt_q     <= '0;
                        state_q   <= ACC_A;
                    end else if (prod_vld) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACC_A: begin
                    if (last_a) begin
                        arousal_q <= ~sum_neg;
                        cnt_q     <= '0;
                        state_q   <= HOLD;
                    end else if (prod_vld) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    // valid rises one cycle after entering HOLD and falls right after fire
                    if (fire) begin
                        dout_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ACC_V;
                    end else begin
                        dout_valid_q <= 1'b1;
                    end
                end
                default: state_q <= ACC_V;
            endcase
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_fire  = fire;
    assign valence    = valence_q;
    assign arousal    = arousal_q;
    assign overrun    = overrun_q | sat;

endmodule

// File: tb/tb_svm_decision.sv
module tb_svm_decision;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: 4+4 support vectors, zero biases, 56-bit accumulator
    logic signed [15:0] m_alpha = '0;
    logic signed [31:0] m_kernel = '0;
    logic m_v = 1'b0, m_a = 1'b0, m_ready = 1'b0;
    logic m_dout_valid, m_fire, m_val, m_aro, m_ovr;

    svm_decision #(
        .VSUP_WIDTH(4), .ASUP_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .alpha(m_alpha), .kernel(m_kernel),
        .v_alpha_valid(m_v), .a_alpha_valid(m_a),
        .dout_valid(m_dout_valid), .dout_ready(m_ready), .dout_fire(m_fire),
        .valence(m_val), .arousal(m_aro), .overrun(m_ovr)
    );

    // narrow instance: 20-bit accumulator, V_BIAS = -6 (tie and overflow cases)
    logic signed [15:0] s_alpha = '0;
    logic signed [31:0] s_kernel = '0;
    logic s_v = 1'b0, s_a = 1'b0, s_ready = 1'b0;
    logic s_dout_valid, s_fire, s_val, s_aro, s_ovr;

    svm_decision #(
        .ACC_BITS(20), .VSUP_WIDTH(4), .ASUP_WIDTH(4), .V_BIAS(-20'sd6)
    ) dut_n (
        .clk(clk), .rst(rst), .alpha(s_alpha), .kernel(s_kernel),
        .v_alpha_valid(s_v), .a_alpha_valid(s_a),
        .dout_valid(s_dout_valid), .dout_ready(s_ready), .dout_fire(s_fire),
        .valence(s_val), .arousal(s_aro), .overrun(s_ovr)
    );

`ifdef SVM_DECISION_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic exp_ovr = 1'b0;

    logic signed [15:0] al_v[4], al_a[4];
    logic signed [31:0] kn_v[4], kn_a[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sign of bias + sum(alpha*kernel) for one phase, plain integer arithmetic
    function automatic logic model_sign(input bit arousal_phase);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            if (arousal_phase) s += longint'(al_a[i]) * longint'(kn_a[i]);
            else               s += longint'(al_v[i]) * longint'(kn_v[i]);
        end
        return (s >= 0);
    endfunction

    task automatic idle_m(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_m(input logic v, input logic a,
                           input logic signed [15:0] al, input logic signed [31:0] kn);
        m_v = v; m_a = a; m_alpha = al; m_kernel = kn;
        @(posedge clk); #1;
        m_v = 1'b0; m_a = 1'b0;
    endtask

    task automatic send_stream(input int gap_max);
        for (int i = 0; i < 4; i++) begin
            idle_m($urandom_range(gap_max, 0));
            drive_m(1'b1, 1'b0, al_v[i], kn_v[i]);
        end
        for (int i = 0; i < 4; i++) begin
            idle_m($urandom_range(gap_max, 0));
            drive_m(1'b0, 1'b1, al_a[i], kn_a[i]);
        end
    endtask

    task automatic wait_valid_m(input logic ev, input logic ea);
        int i = 0;
        while (m_dout_valid !== 1'b1 && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        chk("m_valid", m_dout_valid, 1);
        chk("m_valence", m_val, ev);
        chk("m_arousal", m_aro, ea);
        chk("m_overrun", m_ovr, exp_ovr);
    endtask

    task automatic do_fire_m(input int hold, input logic ev, input logic ea);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("m_hold_stable", {m_dout_valid, m_val, m_aro}, {1'b1, ev, ea});
        end
        m_ready = 1'b1;
        #1;
        chk("m_fire", m_fire, 1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("m_after_fire", {m_dout_valid, m_fire}, 0);
    endtask

    task automatic rand_vectors();
        for (int i = 0; i < 4; i++) begin
            al_v[i] = 16'($urandom); kn_v[i] = 32'($urandom);
            al_a[i] = 16'($urandom); kn_a[i] = 32'($urandom);
        end
    endtask

    initial begin
        logic ev, ea, early;
        longint acc_n;
        bit sat_n;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {m_dout_valid, m_fire, m_val, m_aro, m_ovr}, 0);
        chk("rst_outputs_n", {s_dout_valid, s_fire, s_val, s_aro, s_ovr}, 0);
        rst = 1'b0;

        // narrow instance: valence score exactly 0, arousal overflows 20 bits
        for (int i = 0; i < 4; i++) begin
            s_v = 1'b1; s_alpha = (i == 3) ? 16'sd3 : 16'sd1; s_kernel = 32'sd1;
            @(posedge clk); #1;
        end
        s_v = 1'b0;
        acc_n = 0; sat_n = 0;
        for (int i = 0; i < 4; i++) begin
            s_a = 1'b1; s_alpha = 16'sd32767; s_kernel = 32'sd32767;
            @(posedge clk); #1;
            acc_n = acc_n + longint'(32767) * longint'(32767);
            if (SAT_EN) begin
                if (acc_n > 524287) begin acc_n = 524287; sat_n = 1; end
            end else begin
                acc_n = acc_n & longint'(1048575);
                if (acc_n >= 524288) acc_n = acc_n - 1048576;
            end
        end
        s_a = 1'b0;
        for (int i = 0; i < 40 && s_dout_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("n_valid", s_dout_valid, 1);
        chk("n_valence_tie", s_val, 1);
        chk("n_arousal_wide", s_aro, (acc_n >= 0));
        chk("n_overrun_sat", s_ovr, sat_n);
        s_ready = 1'b1;
        #1;
        chk("n_fire", s_fire, 1);
        @(posedge clk); #1;
        s_ready = 1'b0;

        // directed vector, back-to-back samples, latency of dout_valid
        al_v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        kn_v = '{32'sd10, -32'sd1, -32'sd1, -32'sd1};
        al_a = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        kn_a = '{-32'sd5, 32'sd1, 32'sd1, 32'sd1};
        send_stream(0);
        @(posedge clk); #1;
        chk("lat_not_yet", m_dout_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", m_dout_valid, 1);
        chk("dir_valence", m_val, 1);
        chk("dir_arousal", m_aro, 0);
        do_fire_m(10, 1'b1, 1'b0);

        // second classification right after fire
        al_v = '{16'sd2, 16'sd2, 16'sd2, 16'sd2};
        kn_v = '{-32'sd3, 32'sd1, 32'sd0, 32'sd0};
        al_a = '{16'sd7, -16'sd1, 16'sd0, 16'sd0};
        kn_a = '{32'sd1, 32'sd3, 32'sd9, 32'sd9};
        send_stream(0);
        wait_valid_m(model_sign(0), model_sign(1));
        do_fire_m(0, model_sign(0), model_sign(1));

        // randomized vectors, including extreme operands
        for (int n = 0; n < 20; n++) begin
            rand_vectors();
            if (n % 5 == 4) begin
                for (int i = 0; i < 4; i++) begin
                    al_v[i] = 16'sh8000; kn_v[i] = 32'sh8000_0000;
                    al_a[i] = 16'sh8000; kn_a[i] = 32'sh7fff_ffff;
                end
            end
            ev = model_sign(0);
            ea = model_sign(1);
            early = ($urandom_range(3, 0) == 0);
            if (early) m_ready = 1'b1;
            send_stream(2);
            wait_valid_m(ev, ea);
            do_fire_m(early ? 0 : $urandom_range(3, 0), ev, ea);
        end

        // valence sample during HOLD
        al_v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        kn_v = '{32'sd10, -32'sd1, -32'sd1, -32'sd1};
        al_a = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        kn_a = '{-32'sd5, 32'sd1, 32'sd1, 32'sd1};
        send_stream(0);
        wait_valid_m(1'b1, 1'b0);
        drive_m(1'b1, 1'b0, 16'sd100, -32'sd100);
        exp_ovr = 1'b1;
        chk("hold_ovr", m_ovr, 1);
        chk("hold_result", {m_dout_valid, m_val, m_aro}, 3'b110);
        do_fire_m(2, 1'b1, 1'b0);

        // both valids in ACC_V: dropped
        rand_vectors();
        drive_m(1'b1, 1'b1, 16'sh7fff, 32'sh7fff_ffff);
        send_stream(1);
        wait_valid_m(model_sign(0), model_sign(1));
        do_fire_m(1, model_sign(0), model_sign(1));

        // reset mid-phase aborts the vector
        drive_m(1'b1, 1'b0, 16'sd50, 32'sd50);
        drive_m(1'b1, 1'b0, 16'sd50, 32'sd50);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ovr = 1'b0;
        chk("rst_mid_ovr", m_ovr, 0);
        for (int k = 0; k < 6; k++) begin
            chk("rst_mid_novalid", m_dout_valid, 0);
            @(posedge clk); #1;
        end
        rand_vectors();
        send_stream(0);
        wait_valid_m(model_sign(0), model_sign(1));
        do_fire_m(0, model_sign(0), model_sign(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
